// File: rtl/sub64_pkg.sv
// Shared widths and the stage-1 record for the pipelined 64-bit subtractor.
// Optional flag outputs in sub64_pipe are enabled by defining SUB64_FLAGS_EN.
package sub64_pkg;

  localparam int DATA_W = 64;
  localparam int LO_W   = 32;
  localparam int HI_W   = DATA_W - LO_W;

  // Stage-1 contents at the default widths.
  typedef struct packed {
    logic [LO_W-1:0] d_lo;
    logic            bl;
    logic [HI_W-1:0] a_hi;
    logic [HI_W-1:0] b_hi;
  } s1_rec_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract slice: diff = x - y - bin, built as x + ~y + ~bin.
module sub_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         msb_ovf
);

  logic         nb;
  logic         c;
  logic [W:0]   sum;

  // Inverting before widening keeps the carry-in at exactly 0 or 1.
  assign nb          = ~bin;
  assign sum         = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, nb};
  assign {c, diff}   = sum;
  assign bout        = ~c;
  assign msb_ovf     = (x[W-1] != y[W-1]) & (diff[W-1] != x[W-1]);

endmodule

// File: rtl/sub64_pipe.sv
// Two-stage valid/ready subtractor: d = a - b - bin, low slice in S1, high slice in S2.
// Defining SUB64_FLAGS_EN adds the zero and ovf_sticky outputs.
module sub64_pipe
  import sub64_pkg::*;
#(
  parameter int DATA_W = sub64_pkg::DATA_W,
  parameter int LO_W   = sub64_pkg::LO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] d,
  output logic              bout,
  output logic              ovf
`ifdef SUB64_FLAGS_EN
  ,
  output logic              zero,
  output logic              ovf_sticky
`endif
);

  localparam int HI_W = DATA_W - LO_W;

  typedef struct packed {
    logic [LO_W-1:0] d_lo;
    logic            bl;
    logic [HI_W-1:0] a_hi;
    logic [HI_W-1:0] b_hi;
  } s1_t;

  s1_t             s1_q;
  s1_t             s1_d;
  logic            s1_valid;
  logic            s2_valid;
  logic            s2_free;
  logic            s1_adv;
  logic            accept;

  logic [LO_W-1:0] lo_diff;
  logic            lo_bout;
  logic            lo_ovf_unused;
  logic [HI_W-1:0] hi_diff;
  logic            hi_bout;
  logic            hi_ovf;

  // Ready is derived from pipeline state and out_ready only, never from in_valid.
  assign s2_free   = ~s2_valid | out_ready;
  assign s1_adv    = s1_valid & s2_free;
  assign in_ready  = ~s1_valid | s2_free;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  sub_slice #(.W(LO_W)) u_lo (
    .x       (a[LO_W-1:0]),
    .y       (b[LO_W-1:0]),
    .bin     (bin),
    .diff    (lo_diff),
    .bout    (lo_bout),
    .msb_ovf (lo_ovf_unused)
  );

  assign s1_d = '{d_lo: lo_diff, bl: lo_bout, a_hi: a[DATA_W-1:LO_W], b_hi: b[DATA_W-1:LO_W]};

  sub_slice #(.W(HI_W)) u_hi (
    .x       (s1_q.a_hi),
    .y       (s1_q.b_hi),
    .bin     (s1_q.bl),
    .diff    (hi_diff),
    .bout    (hi_bout),
    .msb_ovf (hi_ovf)
  );

  // NOTE: state is updated with <= so every register samples pre-edge values,
  // which is what lets S2 drain, S1 advance and S1 refill in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      // NOTE: data registers are reset too, so outputs read 0 rather than X after reset.
      s1_q     <= '0;
      d        <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      s1_valid <= accept | (s1_valid & ~s1_adv);
      s2_valid <= s1_adv | (s2_valid & ~out_ready);
      if (accept) s1_q <= s1_d;
      if (s1_adv) begin
        d    <= {hi_diff, s1_q.d_lo};
        bout <= hi_bout;
        ovf  <= hi_ovf;
      end
    end
  end

`ifdef SUB64_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (s1_adv) zero <= ({hi_diff, s1_q.d_lo} == '0);
      // Sticky records results actually handed downstream.
      if (s2_valid & out_ready & ovf) ovf_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sub64_pipe.sv
// Self-checking bench for sub64_pipe: vector table, handshake corner sequences, random vs model.
module tb_sub64_pipe;
  import sub64_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              bout;
    logic              ovf;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              bin;
    logic [DATA_W-1:0] d;
    logic              bout;
    logic              ovf;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              bin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] d;
  logic              bout;
  logic              ovf;
`ifdef SUB64_FLAGS_EN
  logic              zero;
  logic              ovf_sticky;
`endif

  int                n_checks = 0;
  int                n_fail   = 0;
  int                n_emit   = 0;
  exp_t              exp_q[$];
  exp_t              cur_exp;
  bit                acc;
  logic              obs_in_ready;
  logic              obs_out_valid;
  logic [DATA_W-1:0] obs_d;

  localparam int NV = 7;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  sub64_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d          (d),
    .bout       (bout),
    .ovf        (ovf)
`ifdef SUB64_FLAGS_EN
    ,
    .zero       (zero),
    .ovf_sticky (ovf_sticky)
`endif
  );

  // Reference: exact wide arithmetic; borrow = result negative, overflow = result outside signed range.
  function automatic exp_t model(logic [DATA_W-1:0] x, logic [DATA_W-1:0] y, logic bi);
    exp_t              e;
    logic [DATA_W:0]   u;
    logic [DATA_W+1:0] s;
    u = {1'b0, x} - {1'b0, y} - {{DATA_W{1'b0}}, bi};
    s = {x[DATA_W-1], x[DATA_W-1], x} - {y[DATA_W-1], y[DATA_W-1], y} - {{(DATA_W+1){1'b0}}, bi};
    e.d    = u[DATA_W-1:0];
    e.bout = u[DATA_W];
    e.ovf  = !((s[DATA_W+1:DATA_W-1] == 3'b000) || (s[DATA_W+1:DATA_W-1] == 3'b111));
    return e;
  endfunction

  task automatic check(string name, logic [DATA_W-1:0] got, logic [DATA_W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic fail_event(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Inputs are already set for the coming edge; observe handshakes, then move to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    acc           = 1'b0;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_d         = d;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          fail_event("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("d", d, e.d);
          check("bout", {{(DATA_W-1){1'b0}}, bout}, {{(DATA_W-1){1'b0}}, e.bout});
          check("ovf", {{(DATA_W-1){1'b0}}, ovf}, {{(DATA_W-1){1'b0}}, e.ovf});
`ifdef SUB64_FLAGS_EN
          check("zero", {{(DATA_W-1){1'b0}}, zero}, {{(DATA_W-1){1'b0}}, (e.d == '0)});
`endif
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic offer(logic [DATA_W-1:0] x, logic [DATA_W-1:0] y, logic bi);
    a        = x;
    b        = y;
    bin      = bi;
    in_valid = 1'b1;
    cur_exp  = model(x, y, bi);
  endtask

  task automatic send(logic [DATA_W-1:0] x, logic [DATA_W-1:0] y, logic bi);
    offer(x, y, bi);
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) fail_event("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) fail_event("drain_timeout");
  endtask

  task automatic do_reset(int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idx;
    int emit0;
    bit [3:0] exp_ir;

    vecs[0] = '{64'h0000_0001_0000_0000, 64'h1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    vecs[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{64'h5, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[5] = '{64'h0000_0001_0000_0000, 64'h0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    vecs[6] = '{64'hA, 64'h3, 1'b0, 64'h7, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Reset state.
    do_reset(3);
    tick();
    check("rst_out_valid", {63'b0, obs_out_valid}, 64'h0);
    check("rst_in_ready", {63'b0, obs_in_ready}, 64'h1);
    check("rst_d", obs_d, 64'h0);
    check("rst_bout", {63'b0, bout}, 64'h0);
    check("rst_ovf", {63'b0, ovf}, 64'h0);
`ifdef SUB64_FLAGS_EN
    check("rst_zero", {63'b0, zero}, 64'h0);
    check("rst_sticky", {63'b0, ovf_sticky}, 64'h0);
`endif

    // Two-cycle latency with the borrow crossing the slice boundary.
    offer(vecs[0].a, vecs[0].b, vecs[0].bin);
    tick();
    check("lat_accept", {63'b0, acc}, 64'h1);
    in_valid = 1'b0;
    tick();
    check("lat_cycle1", {63'b0, obs_out_valid}, 64'h0);
    tick();
    check("lat_cycle2", {63'b0, obs_out_valid}, 64'h1);

    // Vector table streamed back-to-back: one accept per cycle, expected values from the table.
    emit0 = n_emit;
    for (int i = 0; i < NV; i++) begin
      a = vecs[i].a; b = vecs[i].b; bin = vecs[i].bin; in_valid = 1'b1;
      cur_exp = '{vecs[i].d, vecs[i].bout, vecs[i].ovf};
      tick();
      check("tbl_accept", {63'b0, acc}, 64'h1);
    end
    drain();
    check("tbl_emits", 64'(n_emit - emit0), 64'(NV));

    // Backpressure: out_ready low for 4 cycles while 5 operand sets stream in.
    exp_ir = 4'b0011;
    idx = 0;
    emit0 = n_emit;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(64'(idx + 10), 64'(idx), 1'b0);
      tick();
      check("bp_in_ready", {63'b0, obs_in_ready}, {63'b0, exp_ir[k]});
      if (acc) idx++;
      if (k >= 2) begin
        check("bp_hold_valid", {63'b0, obs_out_valid}, 64'h1);
        check("bp_hold_d", obs_d, 64'd10);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 50 && idx < 5; k++) begin
      offer(64'(idx + 10), 64'(idx), 1'b0);
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_emits", 64'(n_emit - emit0), 64'd5);

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    offer(64'd100, 64'd1, 1'b0); tick();
    offer(64'd200, 64'd2, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    check("full_in_ready", {63'b0, obs_in_ready}, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    tick();
    check("mid_rst_out_valid", {63'b0, obs_out_valid}, 64'h0);
    check("mid_rst_in_ready", {63'b0, obs_in_ready}, 64'h1);
    emit0 = n_emit;
    repeat (4) tick();
    check("no_stale", 64'(n_emit - emit0), 64'h0);

`ifdef SUB64_FLAGS_EN
    check("sticky_clear", {63'b0, ovf_sticky}, 64'h0);
    send(64'h1234, 64'h1234, 1'b0);
    drain();
    check("zero_set", {63'b0, zero}, 64'h1);
    check("sticky_still_clear", {63'b0, ovf_sticky}, 64'h0);
    send(64'h8000_0000_0000_0000, 64'h1, 1'b0);
    drain();
    check("sticky_set", {63'b0, ovf_sticky}, 64'h1);
    send(64'd10, 64'd3, 1'b0);
    drain();
    check("sticky_held", {63'b0, ovf_sticky}, 64'h1);
    check("zero_cleared", {63'b0, zero}, 64'h0);
    do_reset(1);
    check("sticky_rst", {63'b0, ovf_sticky}, 64'h0);
`endif

    // Random traffic with random backpressure against the model.
    in_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          logic [DATA_W-1:0] x;
          logic [DATA_W-1:0] y;
          x = {$urandom, $urandom};
          case ($urandom_range(0, 3))
            0:       y = x;
            1:       y = {x[DATA_W-1:LO_W], 32'($urandom)};
            default: y = {$urandom, $urandom};
          endcase
          offer(x, y, 1'($urandom_range(0, 1)));
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
